// File: rtl/imem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_pkg: shared instruction-memory geometry and loader states   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package imem_pkg;

  localparam int IMEM_AW    = 10;
  localparam int IMEM_DW    = 16;
  localparam int IMEM_DEPTH = 1000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_word_assembler: high/low byte pair register, high byte first|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_word_assembler
  import imem_pkg::*;
#(
  parameter int DW = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_hi,
  input  logic          load_lo,
  input  logic [7:0]    byte_data,
  output logic [DW-1:0] word,
  output logic          word_valid
);

  logic [7:0] hi_byte;
  logic [7:0] lo_byte;

  // word_valid marks the single cycle right after the low byte lands
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte    <= '0;
      lo_byte    <= '0;
      word_valid <= 1'b0;
    end else begin
      if (load_hi) hi_byte <= byte_data;
      if (load_lo) lo_byte <= byte_data;
      word_valid <= load_lo;
    end
  end

  assign word = {hi_byte, lo_byte};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader: byte-stream writer for the instruction memory       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_loader
  import imem_pkg::*;
#(
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] word_count,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  loader_state_t state, state_next;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;
  logic [AW:0]   addr_inc;
  logic          load_hi, load_lo, capture, step;
  logic [DW-1:0] word;
  logic          word_valid;

  imem_word_assembler #(.DW(DW)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .load_hi    (load_hi),
    .load_lo    (load_lo),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // One extra bit so the overflow test sees DEPTH itself, never a wrapped value
  assign addr_inc = {1'b0, addr} + (AW+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (capture) begin
      addr      <= base_addr;
      remaining <= word_count;
    end else if (step) begin
      addr      <= addr_inc[AW-1:0];
      remaining <= remaining - AW'(1);
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0)                 state_next = FIN;
          else if ({1'b0, base_addr} >= DEPTH_W) state_next = ERR;
          else begin
            capture    = 1'b1;
            state_next = HI;
          end
        end
      end
      HI: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          load_hi    = 1'b1;
          state_next = LO;
        end
      end
      LO: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          load_lo    = 1'b1;
          state_next = WR;
        end
      end
      WR: begin
        busy    = 1'b1;
        wr_en   = word_valid;
        wr_addr = addr;
        wr_data = word;
        step    = 1'b1;
        if (remaining == AW'(1))     state_next = FIN;
        else if (addr_inc >= DEPTH_W) state_next = ERR;
        else                          state_next = HI;
      end
      FIN:     begin done  = 1'b1; state_next = IDLE; end
      ERR:     begin error = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
    // Reset silences everything in the very cycle it is asserted
    if (rst) begin
      in_ready = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      busy     = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      load_hi  = 1'b0;
      load_lo  = 1'b0;
      capture  = 1'b0;
      step     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_imem_loader: randomized loads against a word-list reference   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, wr_en, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  imem_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [30:0] outs = {in_ready, wr_en, busy, done, error, wr_addr, wr_data};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor: only this block writes these, the driver reads deltas
  logic [25:0] got_q[$];
  int   xfer_cnt = 0, done_cnt = 0, err_cnt = 0, lat_bad = 0, mx_bad = 0;
  int   term_cyc = 0, last_wr_cyc = 0;
  logic busy_at_term = 1'b0, busy_prev_term = 1'b0, prev_xfer = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (in_valid && in_ready) xfer_cnt++;
    if (wr_en) begin
      got_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      if (!prev_xfer) lat_bad++;
    end
    if (done || error) begin
      term_cyc       = cyc;
      busy_at_term   = busy;
      busy_prev_term = prev_busy;
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (int'(wr_en) + int'(done) + int'(error) > 1) mx_bad++;
    prev_xfer = in_valid && in_ready;
    prev_busy = busy;
  end

  logic [7:0] stim [0:31];

  // bp: 0 = always valid, 1 = random valid, 2 = toggling valid with a 5-cycle gap
  task automatic run_load(input int base, input int cnt, input int nbytes, input int bp, input bit poke);
    logic [25:0] exp_q[$];
    int  nw, q0, x0, d0, e0, i, budget, set_cyc, nget;
    bit  exp_done, exp_err, took;
    logic busy_snap;
    nw = 0; exp_done = 0; exp_err = 0;
    if (cnt == 0) exp_done = 1;
    else if (base >= DEPTH) exp_err = 1;
    else begin
      nw = (base + cnt <= DEPTH) ? cnt : DEPTH - base;
      for (int k = 0; k < nw; k++) exp_q.push_back({10'(base + k), stim[2*k], stim[2*k+1]});
      if (base + cnt <= DEPTH) exp_done = 1; else exp_err = 1;
    end

    q0 = got_q.size(); x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'(base); word_count = 10'(cnt); set_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'($urandom); word_count = 10'($urandom);
    busy_snap = busy;

    i = 0; budget = 0;
    while (i < nbytes && (done_cnt - d0) + (err_cnt - e0) == 0 && budget < 500) begin
      in_data = stim[i];
      case (bp)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = (budget % 2 == 0) && !(budget >= 3 && budget < 8);
      endcase
      if (poke && i == 1) begin
        start = 1'b1; base_addr = 10'd500; word_count = 10'd7;
      end else start = 1'b0;
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) i++;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0;
    budget = 0;
    while ((done_cnt - d0) + (err_cnt - e0) == 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    // Offer bytes while idle; none may be taken
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    check("busy_after_start", int'(busy_snap), int'(nw > 0));
    check("write_count", got_q.size() - q0, nw);
    nget = got_q.size() - q0;
    for (int k = 0; k < nw && k < nget; k++) check("write_word", int'(got_q[q0+k]), int'(exp_q[k]));
    check("done_pulses", done_cnt - d0, int'(exp_done));
    check("error_pulses", err_cnt - e0, int'(exp_err));
    check("bytes_taken", xfer_cnt - x0, 2*nw);
    check("busy_at_term", int'(busy_at_term), 0);
    if (nw > 0) begin
      check("term_after_write", term_cyc - last_wr_cyc, 1);
      check("busy_before_term", int'(busy_prev_term), 1);
    end else begin
      check("term_latency", int'((term_cyc - set_cyc) >= 1 && (term_cyc - set_cyc) <= 2), 1);
    end
  endtask

  task automatic reset_mid_load();
    int  q0, i, budget;
    bit  took;
    for (int k = 0; k < 6; k++) stim[k] = 8'($urandom);
    q0 = got_q.size();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd10; word_count = 10'd3;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; budget = 0;
    while (i < 3 && budget < 50) begin
      in_data = stim[i]; in_valid = 1'b1;
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) i++;
      budget++;
    end
    in_data = stim[3]; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("reset_cycle_outputs", int'({1'b0, outs}), 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("after_reset_outputs", int'({1'b0, outs}), 0);
    @(posedge clk); #1;
    check("reset_write_count", got_q.size() - q0, 1);
    if (got_q.size() > q0) check("reset_word0", int'(got_q[q0]), int'({10'd10, stim[0], stim[1]}));
  endtask

  initial begin
    int base, cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({1'b0, outs}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'({1'b0, outs}), 0);

    // Basic load, then identical load with backpressure
    stim[0] = 8'h80; stim[1] = 8'h80; stim[2] = 8'h01;
    stim[3] = 8'hF4; stim[4] = 8'h84; stim[5] = 8'h02;
    run_load(0, 3, 6, 0, 1'b0);
    run_load(0, 3, 6, 2, 1'b0);

    // Overflow past the last address, and a base already out of range
    for (int k = 0; k < 6; k++) stim[k] = 8'($urandom);
    run_load(998, 3, 6, 0, 1'b0);
    run_load(1000, 1, 2, 0, 1'b0);

    // Zero count
    run_load(123, 0, 2, 0, 1'b0);

    // Start while busy is ignored
    for (int k = 0; k < 4; k++) stim[k] = 8'($urandom);
    run_load(40, 2, 4, 0, 1'b1);

    reset_mid_load();
    stim[0] = 8'h14; stim[1] = 8'h01;
    run_load(21, 1, 2, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       base = int'($urandom_range(0, 990));
        1:       base = int'($urandom_range(990, 999));
        2:       base = int'($urandom_range(1000, 1023));
        default: base = int'($urandom_range(0, 1023));
      endcase
      cnt = int'($urandom_range(0, 6));
      for (int k = 0; k < 32; k++) stim[k] = 8'($urandom);
      run_load(base, cnt, 2*cnt + int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    check("strobes_exclusive", mx_bad, 0);
    check("write_follows_low_byte", lat_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: fills the 16-bit-wide, 10-bit-addressed instruction store at run time instead of from hard-coded initial contents.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 16-bit words, high byte first.
- Issues one write per word at consecutive addresses, starting from a programmable base address.
- Sits between the host/boot link and the write port of a writable instruction memory. The CPU fetch path is untouched.

Parameters:
- AW, 10, address width of the instruction memory.
- DW, 16, instruction word width; must equal 2×8.
- DEPTH, 1000, number of valid words; addresses 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  AW  first write address; captured on accepted start.
- word_count  in  AW  number of words to load; captured on accepted start.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  DW  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse: load completed normally.
- error  out  1  one-cycle pulse: load aborted on address overflow.

Behaviour:
- Reset: all outputs are 0. State is IDLE. Byte and word registers are cleared.
- Reset mid-load: the load is abandoned. No write is issued in the reset cycle or after it.
- Byte transfer: a byte transfers on a cycle where in_valid && in_ready. in_ready is high only in states HI and LO.
- IDLE:
  - start=1 with word_count=0 → go to FIN; done pulses next cycle and no write occurs.
  - start=1 with base_addr >= DEPTH → error pulses next cycle.
  - start=1 otherwise → capture base_addr and word_count, set busy=1, go to HI.
- HI: on a transfer, latch in_data into word[15:8], go to LO.
- LO: on a transfer, latch in_data into word[7:0], go to WR.
- WR (exactly one cycle):
  - wr_en=1, wr_addr=current address, wr_data=assembled word. in_ready=0.
  - Decrement the remaining count and increment the address.
  - remaining becomes 0 → FIN.
  - Else next address >= DEPTH → ERR.
  - Else → HI.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- ERR: error=1 for one cycle, busy=0, return to IDLE. Bytes already written stay in memory.
- Latency: wr_en is asserted the cycle after the low byte is accepted. Maximum throughput is 1 word per 3 cycles.
- Backpressure: in_valid may drop at any point; the state holds with no timeout. No byte is lost or duplicated.
- Ignored inputs:
  - start while busy has no effect.
  - in_data when in_ready=0 is ignored.
- Width rules:
  - Address increments in AW bits.
  - The overflow test compares against DEPTH and is not a modulo-2^AW wrap. The address never wraps to 0.
- wr_en, done and error are mutually exclusive and never asserted in the same cycle.

Decomposition:
- Package imem_pkg holds:
  - constants IMEM_AW=10, IMEM_DW=16, IMEM_DEPTH=1000;
  - the loader state enum: IDLE, HI, LO, WR, FIN, ERR.
- The instruction memory reuses IMEM_AW/IMEM_DW from the package.
- One natural sub-module: imem_word_assembler, the HI/LO byte-pair register with a word_valid output. The FSM and address counter stay in imem_loader.

Test Plan:
- Basic load: base=0, count=3, bytes 0x80,0x80,0x01,0xF4,0x84,0x02 with in_valid held high → writes (0,0x8080), (1,0x01F4), (2,0x8402), each 1 cycle after its low byte; done pulses once; busy falls with done.
- Backpressure: same load with in_valid toggled 1/0 every cycle plus a 5-cycle gap mid-word → identical write sequence; no extra wr_en.
- Overflow: base=998, count=3, six bytes offered → writes at 998 and 999 only; error pulses after the second write; in_ready stays 0 afterwards; no write at 1000. Separately, base=1000, count=1 → error pulse with no write.
- Zero count: start with count=0 → done pulses within 2 cycles; wr_en never asserted; in_ready stays 0.
- Start while busy: during a count=2 load, assert start with base=500 → ignored; writes go to base and base+1 of the original request.
- Reset mid-load: assert rst after the high byte of word 2 is accepted → next cycle all outputs are 0 and no write occurs. A fresh load of 1 word to address 21 with bytes 0x14,0x01 → single write (21,0x1401).
